// File: rtl/alu_issue_r32.sv
// alu_issue_r32: single-issue RV32 front end for an external combinational ALU.
// It accepts one instruction, reads operands from a local 32-entry register
// file, waits one cycle for the ALU, then writes the result back. Instructions
// are strictly serialised (IDLE -> DECODE -> EXEC -> WB), so no forwarding is needed.
module alu_issue_r32 #(
  parameter int unsigned INSTR_LENGTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [INSTR_LENGTH-1:0] instr,
  output logic                    instr_ready,
  output logic [INSTR_LENGTH-1:0] alu_data1,
  output logic [INSTR_LENGTH-1:0] alu_data2,
  output logic [INSTR_LENGTH-1:0] alu_op,
  input  logic [INSTR_LENGTH-1:0] alu_result,
  output logic                    wb_valid,
  output logic [4:0]              wb_rd,
  output logic [INSTR_LENGTH-1:0] wb_data,
  output logic                    illegal,
  input  logic [4:0]              dbg_raddr,
  output logic [INSTR_LENGTH-1:0] dbg_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [INSTR_LENGTH-1:0] instr_q, instr_d;
  logic [INSTR_LENGTH-1:0] alu_data1_q, alu_data1_d;
  logic [INSTR_LENGTH-1:0] alu_data2_q, alu_data2_d;
  logic [INSTR_LENGTH-1:0] alu_op_q, alu_op_d;
  logic [INSTR_LENGTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]              wb_rd_q, wb_rd_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    illegal_q, illegal_d;
  logic [INSTR_LENGTH-1:0] rf_q [32];

  // Instruction field decode of the latched word
  logic [6:0]              opcode;
  logic [2:0]              funct3;
  logic [6:0]              funct7;
  logic [4:0]              rs1;
  logic [4:0]              rs2;
  logic                    is_itype;
  logic                    is_rtype;
  logic [INSTR_LENGTH-1:0] imm_sext;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign funct7   = instr_q[31:25];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign imm_sext = {{(INSTR_LENGTH-12){instr_q[31]}}, instr_q[31:20]};

  // Supported subset: ADDI/SLTI/ANDI and ADD/SUB
  assign is_itype = (opcode == 7'b0010011) &&
                    ((funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b111));
  assign is_rtype = (opcode == 7'b0110011) && (funct3 == 3'b000) &&
                    ((funct7 == 7'b0000000) || (funct7 == 7'b0100000));

  // Handshake is masked during reset so no transfer can appear accepted
  assign instr_ready = (state_q == IDLE) && rst;
  assign alu_data1   = alu_data1_q;
  assign alu_data2   = alu_data2_q;
  assign alu_op      = alu_op_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign illegal     = illegal_q;
  assign dbg_rdata   = (dbg_raddr == 5'd0) ? '0 : rf_q[dbg_raddr];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath next values; everything holds unless a state updates it
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    alu_data1_d = alu_data1_q;
    alu_data2_d = alu_data2_q;
    alu_op_d    = alu_op_q;
    wb_data_d   = wb_data_q;
    wb_rd_d     = wb_rd_q;
    wb_valid_d  = 1'b0;
    illegal_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (is_itype || is_rtype) begin
          alu_data1_d = (rs1 == 5'd0) ? '0 : rf_q[rs1];
          alu_data2_d = is_rtype ? ((rs2 == 5'd0) ? '0 : rf_q[rs2]) : imm_sext;
          alu_op_d    = instr_q;
          state_d     = EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = IDLE;
        end
      end
      EXEC: begin
        wb_data_d  = alu_result;
        wb_rd_d    = instr_q[11:7];
        wb_valid_d = 1'b1;
        state_d    = WB;
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q     <= '0;
      alu_data1_q <= '0;
      alu_data2_q <= '0;
      alu_op_q    <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      wb_valid_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      alu_data1_q <= alu_data1_d;
      alu_data2_q <= alu_data2_d;
      alu_op_q    <= alu_op_d;
      wb_data_q   <= wb_data_d;
      wb_rd_q     <= wb_rd_d;
      wb_valid_q  <= wb_valid_d;
      illegal_q   <= illegal_d;
    end
  end

  // Register file: written at the closing edge of WB; x0 is never written
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if ((state_q == WB) && (wb_rd_q != 5'd0)) begin
      rf_q[wb_rd_q] <= wb_data_q;
    end
  end

endmodule

// File: tb/tb_alu_issue_r32.sv
// Directed bench for alu_issue_r32 with a small behavioural ALU model.
module tb_alu_issue_r32;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_op;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;

  logic        alu_force;
  logic [31:0] alu_force_val;

  int tests;
  int failed;

  alu_issue_r32 #(.INSTR_LENGTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_data1   (alu_data1),
    .alu_data2   (alu_data2),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .illegal     (illegal),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU for the supported subset, optionally overridden
  always_comb begin
    alu_result = 32'd0;
    if (alu_force) begin
      alu_result = alu_force_val;
    end else if (alu_op[6:0] == 7'b0110011) begin
      alu_result = alu_op[30] ? (alu_data1 - alu_data2) : (alu_data1 + alu_data2);
    end else if (alu_op[6:0] == 7'b0010011) begin
      case (alu_op[14:12])
        3'b000:  alu_result = alu_data1 + alu_data2;
        3'b010:  alu_result = ($signed(alu_data1) < $signed(alu_data2)) ? 32'd1 : 32'd0;
        3'b111:  alu_result = alu_data1 & alu_data2;
        default: alu_result = 32'd0;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for IDLE, present one instruction, return in the DECODE cycle
  task automatic send(input logic [31:0] w);
    for (int i = 0; i < 8; i++) begin
      if (instr_ready) break;
      tick();
    end
    chk("send_ready", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1;
    instr       = w;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic rd_rf(input string tag, input logic [4:0] idx, input logic [31:0] exp);
    dbg_raddr = idx;
    #1;
    chk(tag, dbg_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] bb_instr [4];
  logic [4:0]  bb_rd    [4];
  logic [31:0] bb_res   [4];

  initial begin
    tests         = 0;
    failed        = 0;
    rst           = 1'b0;
    instr_valid   = 1'b0;
    instr         = 32'd0;
    dbg_raddr     = 5'd1;
    alu_force     = 1'b0;
    alu_force_val = 32'd0;

    // Reset state
    tick(); tick();
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_illegal",  {31'd0, illegal},  32'd0);
    chk("rst_data1",    alu_data1, 32'd0);
    chk("rst_data2",    alu_data2, 32'd0);
    chk("rst_op",       alu_op,    32'd0);
    chk("rst_wb_data",  wb_data,   32'd0);
    chk("rst_wb_rd",    {27'd0, wb_rd}, 32'd0);
    chk("rst_rf1",      dbg_rdata, 32'd0);
    rst = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, instr_ready}, 32'd1);

    // ADDI x1,x0,5
    send(32'h00500093);
    chk("addi_dec_ready", {31'd0, instr_ready}, 32'd0);
    chk("addi_dec_wbv",   {31'd0, wb_valid},    32'd0);
    tick();
    chk("addi_ex_d1",  alu_data1, 32'd0);
    chk("addi_ex_d2",  alu_data2, 32'd5);
    chk("addi_ex_op",  alu_op,    32'h00500093);
    chk("addi_ex_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    chk("addi_wb_wbv",  {31'd0, wb_valid}, 32'd1);
    chk("addi_wb_rd",   {27'd0, wb_rd},    32'd1);
    chk("addi_wb_data", wb_data,           32'd5);
    tick();
    chk("addi_idle_wbv",   {31'd0, wb_valid},    32'd0);
    chk("addi_idle_ready", {31'd0, instr_ready}, 32'd1);
    chk("addi_hold_data",  wb_data,              32'd5);
    rd_rf("addi_rf1", 5'd1, 32'd5);

    // ADDI x2,x0,-3
    send(32'hFFD00113);
    tick();
    chk("neg_ex_d2", alu_data2, 32'hFFFFFFFD);
    tick();
    chk("neg_wb_data", wb_data, 32'hFFFFFFFD);
    tick();
    rd_rf("neg_rf2", 5'd2, 32'hFFFFFFFD);

    // SUB x3,x1,x2 -> 5 - (-3) = 8
    send(32'h402081B3);
    tick();
    chk("sub_ex_d1", alu_data1, 32'd5);
    chk("sub_ex_d2", alu_data2, 32'hFFFFFFFD);
    tick();
    chk("sub_wb_rd",   {27'd0, wb_rd}, 32'd3);
    chk("sub_wb_data", wb_data,        32'd8);
    tick();
    rd_rf("sub_rf3", 5'd3, 32'd8);

    // ADD x0,x0,x0 with a forced ALU result
    alu_force     = 1'b1;
    alu_force_val = 32'h00001234;
    send(32'h00000033);
    tick();
    tick();
    chk("x0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("x0_wb_data",  wb_data,           32'h00001234);
    chk("x0_wb_rd",    {27'd0, wb_rd},    32'd0);
    tick();
    alu_force = 1'b0;
    rd_rf("x0_rf0", 5'd0, 32'd0);

    // Unsupported: opcode 0110011, funct3 001
    send(32'h00209233);
    chk("ill_dec_illegal", {31'd0, illegal}, 32'd0);
    tick();
    chk("ill_pulse",   {31'd0, illegal},     32'd1);
    chk("ill_no_wbv",  {31'd0, wb_valid},    32'd0);
    chk("ill_ready",   {31'd0, instr_ready}, 32'd1);
    chk("ill_op_kept", alu_op,               32'h00000033);
    tick();
    chk("ill_pulse_end", {31'd0, illegal},  32'd0);
    chk("ill_no_wbv2",   {31'd0, wb_valid}, 32'd0);
    rd_rf("ill_rf4", 5'd4, 32'd0);

    // Back-to-back dependent chain with instr_valid held high
    bb_instr[0] = 32'h00100293; bb_rd[0] = 5'd5; bb_res[0] = 32'd1; // ADDI x5,x0,1
    bb_instr[1] = 32'h00228313; bb_rd[1] = 5'd6; bb_res[1] = 32'd3; // ADDI x6,x5,2
    bb_instr[2] = 32'h00637393; bb_rd[2] = 5'd7; bb_res[2] = 32'd2; // ANDI x7,x6,6
    bb_instr[3] = 32'h0033A413; bb_rd[3] = 5'd8; bb_res[3] = 32'd1; // SLTI x8,x7,3
    instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = bb_instr[k];
      chk("bb_ready_idle", {31'd0, instr_ready}, 32'd1);
      tick();
      chk("bb_ready_dec",  {31'd0, instr_ready}, 32'd0);
      tick();
      chk("bb_ready_ex",   {31'd0, instr_ready}, 32'd0);
      tick();
      chk("bb_ready_wb",   {31'd0, instr_ready}, 32'd0);
      chk("bb_wbv",        {31'd0, wb_valid},    32'd1);
      chk("bb_rd",         {27'd0, wb_rd},       {27'd0, bb_rd[k]});
      chk("bb_data",       wb_data,              bb_res[k]);
      tick();
    end
    instr_valid = 1'b0;
    rd_rf("bb_rf6", 5'd6, 32'd3);
    rd_rf("bb_rf8", 5'd8, 32'd1);

    // Reset during EXEC aborts the instruction
    send(32'h00700493);   // ADDI x9,x0,7
    tick();
    rst = 1'b0;
    #1;
    chk("abort_wbv",  {31'd0, wb_valid}, 32'd0);
    chk("abort_d1",   alu_data1, 32'd0);
    chk("abort_d2",   alu_data2, 32'd0);
    chk("abort_op",   alu_op,    32'd0);
    chk("abort_data", wb_data,   32'd0);
    chk("abort_rd",   {27'd0, wb_rd}, 32'd0);
    chk("abort_ill",  {31'd0, illegal}, 32'd0);
    rd_rf("abort_rf1", 5'd1, 32'd0);
    tick();
    chk("abort_wbv2", {31'd0, wb_valid}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_ready", {31'd0, instr_ready}, 32'd1);
    chk("abort_wbv3",  {31'd0, wb_valid},    32'd0);
    send(32'h00700493);
    tick();
    tick();
    chk("rec_wbv",  {31'd0, wb_valid}, 32'd1);
    chk("rec_rd",   {27'd0, wb_rd},    32'd9);
    chk("rec_data", wb_data,           32'd7);
    tick();
    rd_rf("rec_rf9", 5'd9, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
